// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI-Stream packet arbiters.
package axis_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Round-robin successor of idx among n channels, wrapping n-1 -> 0.
  function automatic int rr_next_idx(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: the first set request bit found by
// scanning last_grant+1 upward with wrap; last_grant itself is scanned last.
module rr_priority_picker
  import axis_arb_pkg::*;
#(
  parameter int N = 5,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_grant,
  output logic [W-1:0] pick,
  output logic         any_req
);

  // Scan all N positions starting after last_grant; the first hit wins.
  always_comb begin
    int cand;
    logic found;
    logic [N-1:0] req_sh;
    pick    = '0;
    any_req = |req;
    found   = 1'b0;
    req_sh  = '0;
    cand    = int'(last_grant);
    for (int k = 0; k < N; k++) begin
      cand   = rr_next_idx(cand, N);
      req_sh = req >> cand;
      if (!found && req_sh[0]) begin
        found = 1'b1;
        pick  = W'(cand);
      end
    end
  end

endmodule

// File: rtl/axis_mux_rr_arbiter.sv
// Packet-level round-robin arbiter for an N:1 AXI-Stream mux.
// The grant is held for a whole packet and re-arbitrated on its last beat
// without an idle cycle.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ARB_IDLE  | no grant; en=0, waiting for any request
// ARB_GRANT | ctrl selects the granted input; held until the last beat
module axis_mux_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int CHANNEL_NUMBER       = 5,
  parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
  parameter int MAX_BEATS            = 0
) (
  input  logic                            ACLK,
  input  logic                            ARESETn,
  input  logic [CHANNEL_NUMBER-1:0]       req,
  input  logic                            out_tvalid,
  input  logic                            out_tready,
  input  logic                            out_tlast,
  output logic                            en,
  output logic [CHANNEL_NUMBER_WIDTH-1:0] ctrl,
  output logic                            busy
);

  localparam int BW         = ($clog2(MAX_BEATS + 1) > 1) ? $clog2(MAX_BEATS + 1) : 1;
  localparam int LAST_CNT_I = (MAX_BEATS > 0) ? MAX_BEATS - 1 : 0;
  localparam logic [BW-1:0] LAST_CNT = BW'(LAST_CNT_I);
  localparam logic [CHANNEL_NUMBER_WIDTH-1:0] LG_RST = CHANNEL_NUMBER_WIDTH'(CHANNEL_NUMBER - 1);

  arb_state_t                      state, state_nxt;
  logic [CHANNEL_NUMBER_WIDTH-1:0] ctrl_nxt;
  logic [CHANNEL_NUMBER_WIDTH-1:0] last_grant, last_grant_nxt;
  logic [BW-1:0]                   beat_cnt, beat_cnt_nxt;
  logic                            busy_nxt, en_nxt;
  logic [CHANNEL_NUMBER_WIDTH-1:0] pick;
  logic                            any_req;
  logic                            beat, cnt_done, last;

  rr_priority_picker #(
    .N (CHANNEL_NUMBER),
    .W (CHANNEL_NUMBER_WIDTH)
  ) u_picker (
    .req        (req),
    .last_grant (last_grant),
    .pick       (pick),
    .any_req    (any_req)
  );

  assign beat     = en & out_tvalid & out_tready;
  assign cnt_done = (MAX_BEATS != 0) && (beat_cnt == LAST_CNT);
  assign last     = beat & (out_tlast | cnt_done);

  // Next-state decode. Since ctrl == last_grant while granted, the picker
  // only returns ctrl again when no other channel requests, which covers
  // the "solo requester keeps streaming" case without a separate branch.
  always_comb begin
    state_nxt      = state;
    ctrl_nxt       = ctrl;
    last_grant_nxt = last_grant;
    beat_cnt_nxt   = beat_cnt;
    busy_nxt       = busy;
    unique case (state)
      ARB_IDLE: begin
        busy_nxt     = 1'b0;
        beat_cnt_nxt = '0;
        if (any_req) begin
          state_nxt      = ARB_GRANT;
          ctrl_nxt       = pick;
          last_grant_nxt = pick;
        end
      end
      ARB_GRANT: begin
        if (last) begin
          beat_cnt_nxt = '0;
          busy_nxt     = 1'b0;
          if (any_req) begin
            ctrl_nxt       = pick;
            last_grant_nxt = pick;
          end else begin
            state_nxt = ARB_IDLE;
          end
        end else if (beat) begin
          // Saturate so TLAST-only packets longer than the counter range
          // cannot wrap it.
          if (beat_cnt != '1) beat_cnt_nxt = beat_cnt + 1'b1;
          busy_nxt = 1'b1;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
    en_nxt = (state_nxt == ARB_GRANT);
  end

  // State and registered outputs.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state      <= ARB_IDLE;
      en         <= 1'b0;
      ctrl       <= '0;
      last_grant <= LG_RST;
      beat_cnt   <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      en         <= en_nxt;
      ctrl       <= ctrl_nxt;
      last_grant <= last_grant_nxt;
      beat_cnt   <= beat_cnt_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule
